// File: rtl/edge_stream_checker.sv
// Self-checking scoreboard for the edge-detection output stream: compares
// strobed DUT beats lane by lane against a loadable golden image.
module edge_stream_checker #(
    parameter int DATA_W     = 1,
    parameter int LANES      = 1,
    parameter int OUT_LENGTH = 324,
    parameter int NBEATS     = OUT_LENGTH / LANES,
    parameter int TIMEOUT    = 1024,
    parameter int ERR_W      = 16,
    localparam int AW = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    localparam int BW = $clog2(NBEATS + 1),
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    exp_we,
    input  logic [AW-1:0]           exp_addr,
    input  logic [LANES*DATA_W-1:0] exp_wdata,
    input  logic                    start,
    input  logic                    dut_valid,
    input  logic [LANES*DATA_W-1:0] dut_data,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timed_out,
    output logic                    overrun,
    output logic [ERR_W-1:0]        err_count,
    output logic [BW-1:0]           beat_count,
    output logic                    first_err_valid,
    output logic [AW-1:0]           first_err_idx,
    output logic [LW-1:0]           first_err_lane,
    output logic [DATA_W-1:0]       first_err_got,
    output logic [DATA_W-1:0]       first_err_exp
);

    localparam int W  = LANES * DATA_W;
    localparam int CW = $clog2(LANES + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_TOUT
    } state_t;

    state_t state, state_next;

    logic [W-1:0]      mem [NBEATS];
    logic [W-1:0]      exp_beat;
    logic [TW-1:0]     idle_cnt;
    logic [CW-1:0]     mis_cnt;
    logic              mis_any;
    logic [LW-1:0]     mis_lane;
    logic [DATA_W-1:0] mis_got;
    logic [DATA_W-1:0] mis_exp;
    logic [ERR_W:0]    err_sum;
    logic [ERR_W-1:0]  err_next;
    logic              beat_fire;
    logic              last_beat;
    logic              idle_expire;
    logic              mem_wr_ok;

    // Golden image is never reset so it survives an aborted run.
    assign mem_wr_ok = exp_we && (state == S_IDLE || state == S_DONE) &&
                       ({1'b0, exp_addr} < (AW + 1)'(NBEATS));

    always_ff @(posedge clk) begin
        if (mem_wr_ok)
            mem[exp_addr] <= exp_wdata;
    end

    assign exp_beat = mem[beat_count[AW-1:0]];

    always_comb begin
        mis_cnt  = '0;
        mis_any  = 1'b0;
        mis_lane = '0;
        mis_got  = '0;
        mis_exp  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (dut_data[i*DATA_W +: DATA_W] != exp_beat[i*DATA_W +: DATA_W]) begin
                mis_cnt = mis_cnt + 1'b1;
                if (!mis_any) begin
                    mis_lane = LW'(i);
                    mis_got  = dut_data[i*DATA_W +: DATA_W];
                    mis_exp  = exp_beat[i*DATA_W +: DATA_W];
                end
                mis_any = 1'b1;
            end
        end
    end

    assign err_sum  = {1'b0, err_count} + (ERR_W + 1)'(mis_cnt);
    assign err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

    assign beat_fire   = (state == S_RUN) && dut_valid;
    assign last_beat   = beat_fire && (beat_count == BW'(NBEATS - 1));
    assign idle_expire = (state == S_RUN) && !dut_valid &&
                         (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN: begin
                if (last_beat)
                    state_next = S_DONE;
                else if (idle_expire)
                    state_next = S_TOUT;
            end
            S_DONE: if (start) state_next = S_RUN;
            S_TOUT: if (start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE) || (state == S_TOUT);
    assign timed_out = (state == S_TOUT);

    always_ff @(posedge clk) begin
        if (reset || (start && state != S_RUN)) begin
            err_count       <= '0;
            beat_count      <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_lane  <= '0;
            first_err_got   <= '0;
            first_err_exp   <= '0;
            overrun         <= 1'b0;
            pass            <= 1'b0;
            idle_cnt        <= '0;
        end else if (beat_fire) begin
            idle_cnt   <= '0;
            beat_count <= beat_count + 1'b1;
            err_count  <= err_next;
            if (!first_err_valid && mis_any) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= beat_count[AW-1:0];
                first_err_lane  <= mis_lane;
                first_err_got   <= mis_got;
                first_err_exp   <= mis_exp;
            end
            // Pass must include the errors of the closing beat itself.
            if (last_beat)
                pass <= (err_next == '0);
        end else if (state == S_RUN) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else if (state == S_DONE && dut_valid) begin
            overrun <= 1'b1;
            pass    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_stream_checker.sv
// Randomized bench for edge_stream_checker: a 1x1-bit instance (short timeout,
// 4-bit error counter) and a 4-lane 5-bit instance, checked against array models.
module tb_edge_stream_checker;

    localparam int NA = 324;
    localparam int NB = 81;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       a_exp_we = 1'b0, a_start = 1'b0, a_dut_valid = 1'b0;
    logic [8:0] a_exp_addr = '0;
    logic       a_exp_wdata = 1'b0, a_dut_data = 1'b0;
    logic       a_busy, a_done, a_pass, a_timed_out, a_overrun, a_fev;
    logic [3:0] a_err_count;
    logic [8:0] a_beat_count, a_fidx;
    logic       a_flane, a_fgot, a_fexp;

    logic        b_exp_we = 1'b0, b_start = 1'b0, b_dut_valid = 1'b0;
    logic [6:0]  b_exp_addr = '0;
    logic [19:0] b_exp_wdata = '0, b_dut_data = '0;
    logic        b_busy, b_done, b_pass, b_timed_out, b_overrun, b_fev;
    logic [15:0] b_err_count;
    logic [6:0]  b_beat_count, b_fidx;
    logic [1:0]  b_flane;
    logic [4:0]  b_fgot, b_fexp;

    edge_stream_checker #(
        .DATA_W(1), .LANES(1), .OUT_LENGTH(NA), .TIMEOUT(16), .ERR_W(4)
    ) dut_a (
        .clk(clk), .reset(reset), .exp_we(a_exp_we), .exp_addr(a_exp_addr),
        .exp_wdata(a_exp_wdata), .start(a_start), .dut_valid(a_dut_valid),
        .dut_data(a_dut_data), .busy(a_busy), .done(a_done), .pass(a_pass),
        .timed_out(a_timed_out), .overrun(a_overrun), .err_count(a_err_count),
        .beat_count(a_beat_count), .first_err_valid(a_fev), .first_err_idx(a_fidx),
        .first_err_lane(a_flane), .first_err_got(a_fgot), .first_err_exp(a_fexp)
    );

    edge_stream_checker #(
        .DATA_W(5), .LANES(4), .OUT_LENGTH(NA), .TIMEOUT(64), .ERR_W(16)
    ) dut_b (
        .clk(clk), .reset(reset), .exp_we(b_exp_we), .exp_addr(b_exp_addr),
        .exp_wdata(b_exp_wdata), .start(b_start), .dut_valid(b_dut_valid),
        .dut_data(b_dut_data), .busy(b_busy), .done(b_done), .pass(b_pass),
        .timed_out(b_timed_out), .overrun(b_overrun), .err_count(b_err_count),
        .beat_count(b_beat_count), .first_err_valid(b_fev), .first_err_idx(b_fidx),
        .first_err_lane(b_flane), .first_err_got(b_fgot), .first_err_exp(b_fexp)
    );

    int total = 0;
    int bad = 0;

    bit a_gold [NA];
    bit a_flip [NA];
    logic [19:0] b_gold [NB];
    logic [19:0] b_sent [NB];

    int m_err, m_fidx;
    bit m_fv, m_pass;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected status for instance A after n beats of gold^flip.
    task automatic model_a(input int n);
        int cnt = 0;
        m_fidx = 0;
        m_fv = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (a_flip[i]) begin
                if (!m_fv) m_fidx = i;
                m_fv = 1'b1;
                cnt++;
            end
        end
        m_err = (cnt > 15) ? 15 : cnt;
        m_pass = (cnt == 0) && (n == NA);
    endtask

    task automatic load_a(input bit start_on_last);
        for (int i = 0; i < NA; i++) begin
            a_gold[i] = 1'($urandom_range(0, 1));
            a_exp_we = 1'b1;
            a_exp_addr = 9'(i);
            a_exp_wdata = a_gold[i];
            if (start_on_last && i == NA - 1) begin
                a_start = 1'b1;
                a_dut_valid = 1'b1;
                a_dut_data = ~a_gold[0];
            end
            tick();
        end
        a_exp_we = 1'b0;
        a_start = 1'b0;
        a_dut_valid = 1'b0;
    endtask

    task automatic run_a(input int n, input bit do_start);
        if (do_start) begin
            a_start = 1'b1;
            tick();
            a_start = 1'b0;
            total++;
            if (a_busy !== 1'b1 || a_beat_count !== 9'd0) begin
                $display("FAIL run_start busy=%0b beat=%0d required busy=1 beat=0", a_busy, a_beat_count);
                bad++;
            end
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                a_dut_valid = 1'b0;
                a_dut_data = 1'($urandom_range(0, 1));
                tick();
            end
            a_dut_valid = 1'b1;
            a_dut_data = a_gold[i] ^ a_flip[i];
            tick();
        end
        a_dut_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if ({a_busy, a_done, a_pass, a_timed_out, a_overrun, a_err_count, a_beat_count,
             a_fev, a_fidx, a_flane, a_fgot, a_fexp} !== '0) begin
            $display("FAIL reset_a busy=%0b done=%0b pass=%0b err=%0d beat=%0d required all 0",
                     a_busy, a_done, a_pass, a_err_count, a_beat_count);
            bad++;
        end
        total++;
        if ({b_busy, b_done, b_pass, b_timed_out, b_overrun, b_err_count, b_beat_count,
             b_fev, b_fidx, b_flane, b_fgot, b_fexp} !== '0) begin
            $display("FAIL reset_b busy=%0b done=%0b err=%0d beat=%0d required all 0",
                     b_busy, b_done, b_err_count, b_beat_count);
            bad++;
        end
    endtask

    task automatic test_clean_run();
        for (int i = 0; i < NA; i++) a_flip[i] = 1'b0;
        load_a(1'b1);
        total++;
        if (a_busy !== 1'b1 || a_beat_count !== 9'd0) begin
            $display("FAIL start_with_write busy=%0b beat=%0d required busy=1 beat=0", a_busy, a_beat_count);
            bad++;
        end
        run_a(NA, 1'b0);
        model_a(NA);
        total++;
        if (a_done !== 1'b1 || a_pass !== m_pass || a_busy !== 1'b0) begin
            $display("FAIL clean_status done=%0b pass=%0b busy=%0b required 1 %0b 0", a_done, a_pass, a_busy, m_pass);
            bad++;
        end
        total++;
        if (a_err_count !== 4'(m_err) || a_beat_count !== 9'(NA) || a_fev !== m_fv) begin
            $display("FAIL clean_counts err=%0d beat=%0d fev=%0b required %0d %0d %0b",
                     a_err_count, a_beat_count, a_fev, m_err, NA, m_fv);
            bad++;
        end
    endtask

    task automatic test_overrun();
        a_dut_valid = 1'b1;
        a_dut_data = 1'($urandom_range(0, 1));
        tick();
        a_dut_valid = 1'b0;
        total++;
        if (a_overrun !== 1'b1 || a_pass !== 1'b0 || a_err_count !== 4'(m_err) ||
            a_beat_count !== 9'(NA) || a_done !== 1'b1) begin
            $display("FAIL overrun ovr=%0b pass=%0b err=%0d beat=%0d done=%0b required 1 0 %0d %0d 1",
                     a_overrun, a_pass, a_err_count, a_beat_count, a_done, m_err, NA);
            bad++;
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        total++;
        if (a_busy !== 1'b1 || a_done !== 1'b0 || a_overrun !== 1'b0 || a_pass !== 1'b0 ||
            a_err_count !== 4'd0 || a_beat_count !== 9'd0 || a_fev !== 1'b0 || a_timed_out !== 1'b0) begin
            $display("FAIL restart_clear busy=%0b ovr=%0b pass=%0b err=%0d beat=%0d required busy=1 rest 0",
                     a_busy, a_overrun, a_pass, a_err_count, a_beat_count);
            bad++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_two_errors();
        for (int i = 0; i < NA; i++) a_flip[i] = 1'b0;
        a_flip[17] = 1'b1;
        a_flip[200] = 1'b1;
        run_a(NA, 1'b1);
        model_a(NA);
        total++;
        if (a_err_count !== 4'(m_err) || a_pass !== m_pass || a_done !== 1'b1) begin
            $display("FAIL two_err_count err=%0d pass=%0b required %0d %0b", a_err_count, a_pass, m_err, m_pass);
            bad++;
        end
        total++;
        if (a_fev !== m_fv || a_fidx !== 9'(m_fidx) || a_flane !== 1'b0 ||
            a_fgot !== ~a_gold[m_fidx] || a_fexp !== a_gold[m_fidx]) begin
            $display("FAIL two_err_first fev=%0b idx=%0d lane=%0d got=%0b exp=%0b required 1 %0d 0 %0b %0b",
                     a_fev, a_fidx, a_flane, a_fgot, a_fexp, m_fidx, ~a_gold[m_fidx], a_gold[m_fidx]);
            bad++;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        for (int i = 0; i < NA; i++) a_flip[i] = 1'b0;
        run_a(100, 1'b1);
        while (n < 40) begin
            a_start = (n == 0);
            tick();
            a_start = 1'b0;
            n++;
            if (a_timed_out === 1'b1) break;
        end
        total++;
        if (n !== 16) begin
            $display("FAIL timeout_latency cycles=%0d required 16", n);
            bad++;
        end
        total++;
        if (a_timed_out !== 1'b1 || a_done !== 1'b1 || a_pass !== 1'b0 ||
            a_busy !== 1'b0 || a_beat_count !== 9'd100) begin
            $display("FAIL timeout_status tout=%0b done=%0b pass=%0b beat=%0d required 1 1 0 100",
                     a_timed_out, a_done, a_pass, a_beat_count);
            bad++;
        end
        a_dut_valid = 1'b1;
        tick();
        a_dut_valid = 1'b0;
        total++;
        if (a_beat_count !== 9'd100 || a_overrun !== 1'b0 || a_timed_out !== 1'b1) begin
            $display("FAIL tout_valid_ignored beat=%0d ovr=%0b required 100 0", a_beat_count, a_overrun);
            bad++;
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < NA; i++) a_flip[i] = 1'b0;
        for (int k = 0; k < 20; k++) a_flip[k * 16 + $urandom_range(0, 15)] = 1'b1;
        run_a(NA, 1'b1);
        model_a(NA);
        total++;
        if (a_err_count !== 4'(m_err) || a_fidx !== 9'(m_fidx) || a_pass !== 1'b0 || a_done !== 1'b1) begin
            $display("FAIL saturation err=%0d idx=%0d pass=%0b required %0d %0d 0",
                     a_err_count, a_fidx, a_pass, m_err, m_fidx);
            bad++;
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < NA; i++) a_flip[i] = 1'b0;
        run_a(50, 1'b1);
        a_exp_we = 1'b1;
        a_exp_addr = 9'd5;
        a_exp_wdata = ~a_gold[5];
        tick();
        a_exp_we = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({a_busy, a_done, a_pass, a_timed_out, a_overrun, a_err_count, a_beat_count,
             a_fev, a_fidx, a_flane, a_fgot, a_fexp} !== '0) begin
            $display("FAIL reset_mid_run busy=%0b err=%0d beat=%0d required all 0", a_busy, a_err_count, a_beat_count);
            bad++;
        end
        run_a(NA, 1'b1);
        model_a(NA);
        total++;
        if (a_pass !== m_pass || a_err_count !== 4'(m_err) || a_beat_count !== 9'(NA)) begin
            $display("FAIL rerun_after_reset pass=%0b err=%0d beat=%0d required %0b %0d %0d",
                     a_pass, a_err_count, a_beat_count, m_pass, m_err, NA);
            bad++;
        end
    endtask

    task automatic test_lanes();
        int err = 0, fidx = -1, flane = 0;
        logic [4:0] g, s, fg, fe;
        fg = '0;
        fe = '0;
        for (int i = 0; i < NB; i++) begin
            b_gold[i] = 20'($urandom);
            if (i == 3) b_gold[i] = {5'd9, 5'd4, 5'd0, 5'd31};
            b_sent[i] = b_gold[i];
            b_exp_we = 1'b1;
            b_exp_addr = 7'(i);
            b_exp_wdata = b_gold[i];
            tick();
        end
        b_exp_we = 1'b0;
        b_sent[3] = {5'd10, 5'd4, 5'd7, 5'd31};
        for (int i = 0; i < NB; i++) begin
            for (int l = 0; l < 4; l++) begin
                g = b_gold[i][l*5 +: 5];
                s = b_sent[i][l*5 +: 5];
                if (g != s) begin
                    err++;
                    if (fidx < 0) begin
                        fidx = i;
                        flane = l;
                        fg = s;
                        fe = g;
                    end
                end
            end
        end
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            repeat ($urandom_range(0, 3)) begin
                b_dut_valid = 1'b0;
                b_dut_data = 20'($urandom);
                tick();
            end
            b_dut_valid = 1'b1;
            b_dut_data = b_sent[i];
            tick();
        end
        b_dut_valid = 1'b0;
        total++;
        if (b_err_count !== 16'(err) || b_done !== 1'b1 || b_pass !== 1'b0 || b_beat_count !== 7'(NB)) begin
            $display("FAIL lanes_status err=%0d done=%0b pass=%0b beat=%0d required %0d 1 0 %0d",
                     b_err_count, b_done, b_pass, b_beat_count, err, NB);
            bad++;
        end
        total++;
        if (b_fev !== 1'b1 || b_fidx !== 7'(fidx) || b_flane !== 2'(flane) || b_fgot !== fg || b_fexp !== fe) begin
            $display("FAIL lanes_first idx=%0d lane=%0d got=%0d exp=%0d required %0d %0d %0d %0d",
                     b_fidx, b_flane, b_fgot, b_fexp, fidx, flane, fg, fe);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_overrun();
        test_two_errors();
        test_timeout();
        test_saturation();
        test_reset_mid_run();
        test_lanes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
